key_conditioner: RTL and testbench
==================================

// Module: key_conditioner
// PURPOSE
//   Front-end conditioner for the mixer's push-buttons.
//   - Synchronises raw, bouncy button inputs to clk and debounces each one.
//   - Emits a clean level and single-cycle press/release pulses per key.
//   - Sits directly upstream of the mode FSM: key_press[0] drives its modekey input.
//     The FSM therefore advances exactly once per physical press, however long the key is held.
// PARAMETERS
//   NUM_KEYS         4   number of independent button channels
//   DEBOUNCE_CYCLES  16  consecutive synchronised cycles a new level must hold before acceptance (>=2)
//   CNT_W            $clog2(DEBOUNCE_CYCLES)  debounce counter width (derived, not overridden)
// PORTS
//   clk          in   1         system clock (10 MHz)
//   rst          in   1         synchronous, active-high reset
//   raw_keys     in   NUM_KEYS  asynchronous button pins, 1 = pressed
//   key_level    out  NUM_KEYS  debounced level per key, 1 = pressed
//   key_press    out  NUM_KEYS  1-cycle pulse on debounced 0->1
//   key_release  out  NUM_KEYS  1-cycle pulse on debounced 1->0
//   any_press    out  1         OR of key_press, same cycle
// BEHAVIOUR
//   Clock and reset:
//   - Single clock domain; all state updates on posedge clk.
//   - rst sampled at posedge clk only. While high, it clears sync1, sync2, cnt, key_level,
//     key_press, key_release and any_press to 0, overriding all other activity.
//   Per-key pipeline (key i; all keys fully independent):
//   - Two-flop synchroniser: sync1[i] <= raw_keys[i]; sync2[i] <= sync1[i].
//   - Match (sync2[i] == key_level[i]): cnt[i] <= 0.
//   - Mismatch, cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
//   - Mismatch, cnt[i] == DEBOUNCE_CYCLES-1: key_level[i] <= sync2[i]; cnt[i] <= 0.
//   - Net effect: a level is accepted after DEBOUNCE_CYCLES consecutive mismatching cycles.
//   - Any return to match before acceptance restarts the count; there is no partial credit.
//   Pulses (registered):
//   - key_press[i] is high for exactly the one cycle after the edge on which key_level[i] rises.
//   - key_release[i] behaves the same way for a falling key_level[i].
//   - Both pulses are low in all other cycles; they can never be high for two consecutive cycles.
//   Latency:
//   - raw_keys[i] changes before edge 1 and then stays steady.
//   - key_level[i] and the matching pulse update on edge DEBOUNCE_CYCLES+2.
//   - Example, DEBOUNCE_CYCLES=4: update on edge 6.
//   Boundaries:
//   - Glitch of < DEBOUNCE_CYCLES synchronised cycles: no level change, no pulse.
//   - Level held indefinitely: exactly one press pulse; no auto-repeat.
//   - Several keys pressed in the same cycle: pulses assert in the same cycle.
//     any_press is then a single 1-cycle pulse.
//   - Reset mid-debounce: count is discarded.
//   - Key held through reset release: sync2 is 1 by edge 2 after release.
//     A normal press pulse follows on edge DEBOUNCE_CYCLES+2 after release.
//   - Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
// TESTING (DEBOUNCE_CYCLES=4, NUM_KEYS=4, inputs driven at negedge)
//   1 Reset: rst=1 for 2 cycles with raw_keys=4'hF -> all outputs 0 throughout.
//     After release, key_press=4'hF for one cycle on edge 6, then key_level=4'hF.
//   2 Clean press: raw_keys[0] 0->1 and hold -> key_level[0] and key_press[0] rise on edge 6.
//     key_press[0] low on edge 7; any_press mirrors key_press[0].
//   3 Bounce: raw_keys[1] toggles 1,0,1,0 each cycle then holds 1.
//     -> no pulse during toggling; single key_press[1] 6 edges after the final rise.
//   4 Glitch: raw_keys[2] high for 3 cycles then low -> key_level[2] stays 0; no pulses.
//   5 Release: key 0 held, then raw_keys[0] 1->0 -> key_release[0] one cycle on edge 6.
//     key_level[0]=0; key_press[0] stays 0.
//   6 Mid-debounce reset, with FSM downstream: assert rst 2 cycles after raw_keys[3] rises.
//     -> no pulse before rst. Press pulse on edge 6 after rst release.
//     The mode FSM fed by key_press[0] steps 00->01->10->11->00 across four clean presses of key 0.

Source files
------------

// File: rtl/key_conditioner_if.sv
// Button bundle between the raw pin pads, the key conditioner and its consumers.
// The master side drives the pins; the slave side is the conditioner itself.
interface key_conditioner_if #(
    parameter int NUM_KEYS = 4
);

    logic [NUM_KEYS-1:0] raw_keys;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic                any_press;

    modport master (
        output raw_keys,
        input  key_level,
        input  key_press,
        input  key_release,
        input  any_press
    );

    modport slave (
        input  raw_keys,
        output key_level,
        output key_press,
        output key_release,
        output any_press
    );

endinterface

// File: rtl/key_conditioner.sv
// Push-button conditioner: per-key two-flop synchroniser, saturating debounce counter,
// and registered single-cycle press/release pulses that line up with the level change.
module key_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    key_conditioner_if.slave keys
);

    localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] level_q;
    logic [NUM_KEYS-1:0] press_q;
    logic [NUM_KEYS-1:0] release_q;
    logic                any_q;
    logic [CNT_W-1:0]    cnt_q [NUM_KEYS];

    logic [NUM_KEYS-1:0] level_d;
    logic [NUM_KEYS-1:0] press_d;
    logic [NUM_KEYS-1:0] release_d;
    logic [CNT_W-1:0]    cnt_d [NUM_KEYS];

    // Pulses are decided here from the same acceptance condition that updates the
    // level, so level and pulse land on the same edge rather than one cycle apart.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_d[i] = '0;
            if (sync2[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i]   = sync2[i];
                    press_d[i]   = sync2[i];
                    release_d[i] = ~sync2[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Every flop, including the per-key counter array, is cleared by rst so a
    // half-finished debounce can never survive a reset.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            any_q     <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1     <= keys.raw_keys;
            sync2     <= sync1;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            any_q     <= |press_d;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign keys.key_level   = level_q;
    assign keys.key_press   = press_q;
    assign keys.key_release = release_q;
    assign keys.any_press   = any_q;

    // Accepting a level leaves the key matched, so a pulse can never repeat next cycle.
    a_press_single : assert property (@(posedge clk) disable iff (rst)
        (press_q & $past(press_q)) == '0);

    a_release_single : assert property (@(posedge clk) disable iff (rst)
        (release_q & $past(release_q)) == '0);

    a_any_matches : assert property (@(posedge clk) any_q == |press_q);

    generate
        for (genvar g = 0; g < NUM_KEYS; g++) begin : g_cnt_chk
            a_cnt_bound : assert property (@(posedge clk) cnt_q[g] <= CNT_MAX);
        end
    endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4: a per-cycle vector table
// plus hand sequences for bounce, mid-debounce reset and a downstream mode counter.
module tb_key_conditioner;

    localparam int NK = 4;
    localparam int DB = 4;

    logic tb_clk;
    logic rst;

    key_conditioner_if #(.NUM_KEYS(NK)) kif ();

    key_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk  (tb_clk),
        .rst  (rst),
        .keys (kif)
    );

    initial tb_clk = 1'b0;
    always #50 tb_clk = ~tb_clk;

    // Downstream mode FSM stand-in: advances once per key_press[0] pulse.
    logic [1:0] mode;
    always_ff @(posedge tb_clk) begin
        if (rst)                  mode <= 2'b00;
        else if (kif.key_press[0]) mode <= mode + 2'b01;
    end

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] raw;
        logic [3:0] level;
        logic [3:0] press;
        logic [3:0] rel;
        logic       any;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add_rows(input string name, input int n, input logic r,
                                     input logic [3:0] raw, input logic [3:0] lvl,
                                     input logic [3:0] prs, input logic [3:0] rel,
                                     input logic any);
        vec_t v;
        v.name = name; v.rst = r; v.raw = raw;
        v.level = lvl; v.press = prs; v.rel = rel; v.any = any;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    task automatic drive(input logic r, input logic [3:0] raw);
        @(negedge tb_clk);
        rst          = r;
        kif.raw_keys = raw;
    endtask

    task automatic tick_check(input string name, input logic [3:0] lvl, input logic [3:0] prs,
                              input logic [3:0] rel, input logic any);
        @(posedge tb_clk);
        #1;
        check(name, {19'd0, kif.key_level, kif.key_press, kif.key_release, kif.any_press},
                    {19'd0, lvl, prs, rel, any});
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int press_cnt;
        logic [1:0] mode_exp [4];
        mode_exp[0] = 2'b01; mode_exp[1] = 2'b10; mode_exp[2] = 2'b11; mode_exp[3] = 2'b00;

        rst          = 1'b1;
        kif.raw_keys = '0;

        // Reset held with all keys down, then the held keys debounce after release.
        add_rows("rst_hold",      2, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
        add_rows("rst_rel_wait",  5, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
        add_rows("rst_rel_press", 1, 1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 1'b1);
        add_rows("all_held",      3, 1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
        add_rows("all_rel_wait",  5, 1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0);
        add_rows("all_rel",       1, 1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0);
        add_rows("all_idle",      2, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        // Clean press of key 0, long hold with no auto-repeat, then release.
        add_rows("p0_wait",       5, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
        add_rows("p0_press",      1, 1'b0, 4'h1, 4'h1, 4'h1, 4'h0, 1'b1);
        add_rows("p0_hold",       6, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);
        add_rows("r0_wait",       5, 1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0);
        add_rows("r0_release",    1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h1, 1'b0);
        add_rows("r0_idle",       2, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        // Key 2 glitch one cycle short of acceptance.
        add_rows("glitch_hi",     3, 1'b0, 4'h4, 4'h0, 4'h0, 4'h0, 1'b0);
        add_rows("glitch_lo",     6, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].raw);
            tick_check(vecs[i].name, vecs[i].level, vecs[i].press, vecs[i].rel, vecs[i].any);
        end

        // Bounce on key 1: 1,0,1,0 then hold 1.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, (i % 2 == 0) ? 4'h2 : 4'h0);
            tick_check("bounce_toggle", 4'h0, 4'h0, 4'h0, 1'b0);
        end
        drive(1'b0, 4'h2);
        tick_check("bounce_settle", 4'h0, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) tick_check("bounce_settle", 4'h0, 4'h0, 4'h0, 1'b0);
        tick_check("bounce_press", 4'h2, 4'h2, 4'h0, 1'b1);
        tick_check("bounce_after", 4'h2, 4'h0, 4'h0, 1'b0);
        drive(1'b0, 4'h0);
        for (int i = 0; i < 5; i++) tick_check("bounce_rel_wait", 4'h2, 4'h0, 4'h0, 1'b0);
        tick_check("bounce_release", 4'h0, 4'h0, 4'h2, 1'b0);

        // Reset two cycles into a key 3 debounce: count discarded, press follows release.
        drive(1'b0, 4'h8);
        tick_check("mid_rst_pre", 4'h0, 4'h0, 4'h0, 1'b0);
        drive(1'b0, 4'h8);
        tick_check("mid_rst_pre", 4'h0, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'h8);
            tick_check("mid_rst_hold", 4'h0, 4'h0, 4'h0, 1'b0);
        end
        drive(1'b0, 4'h8);
        tick_check("mid_rst_wait", 4'h0, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) tick_check("mid_rst_wait", 4'h0, 4'h0, 4'h0, 1'b0);
        tick_check("mid_rst_press", 4'h8, 4'h8, 4'h0, 1'b1);
        tick_check("mid_rst_after", 4'h8, 4'h0, 4'h0, 1'b0);

        // Four clean presses of key 0 step the mode counter through a full cycle.
        for (int p = 0; p < 4; p++) begin
            press_cnt = 0;
            drive(1'b0, 4'h9);
            for (int c = 0; c < 12; c++) begin
                @(posedge tb_clk);
                #1;
                if (kif.key_press[0]) press_cnt++;
            end
            check("fsm_press_pulses", 32'(press_cnt), 32'd1);
            drive(1'b0, 4'h8);
            for (int c = 0; c < 8; c++) begin
                @(posedge tb_clk);
                #1;
            end
            check("fsm_level_after_rel", {28'd0, kif.key_level}, 32'h8);
            check("fsm_mode", {30'd0, mode}, {30'd0, mode_exp[p]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
